// File: rtl/sequence_detector_pkg.sv
// rtl/sequence_detector_pkg.sv - shared types and helpers for the serial pattern detector
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    // Counter must represent 0..n inclusive
    function automatic int fill_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sequence_detector_if.sv
// rtl/sequence_detector_if.sv - bit-stream input and detection result bundle
interface sequence_detector_if #(
    parameter int CW = 8
) ();
    logic          en;
    logic          d;
    logic          clr;
    logic          match;
    logic          armed;
    logic [CW-1:0] count;

    modport master (
        output en, d, clr,
        input  match, armed, count
    );

    modport slave (
        input  en, d, clr,
        output match, armed, count
    );
endinterface

// File: rtl/sequence_detector_shift_reg.sv
// rtl/sequence_detector_shift_reg.sv - N-bit serial history, newest bit in the LSB
module seq_shift_reg #(
    parameter int N = 4
) (
    input  logic         ck,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         d,
    output logic [N-1:0] hist,
    output logic [N-1:0] hist_next
);

    // hist_next is exported so the compare sees the post-shift window in the same cycle
    generate
        if (N == 1) begin : g_single
            assign hist_next = d;
        end else begin : g_multi
            assign hist_next = {hist[N-2:0], d};
        end
    endgenerate

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            hist <= '0;
        end else if (clr) begin
            hist <= '0;
        end else if (en) begin
            hist <= hist_next;
        end
    end

endmodule

// File: rtl/sequence_detector.sv
// rtl/sequence_detector.sv - serial N-bit pattern detector with match pulse and saturating count
module sequence_detector
    import seq_det_pkg::*;
#(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = N'(DEFAULT_PATTERN),
    parameter int           OVERLAP = 1,
    parameter int           CW      = 8
) (
    input  logic                ck,
    input  logic                reset,
    sequence_detector_if.slave  bus
);

    localparam int            FW   = fill_width(N);
    localparam logic [FW-1:0] FULL = FW'(N);

    logic [N-1:0]  hist;
    logic [N-1:0]  hist_next;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_next;
    logic [FW-1:0] fill_d;
    logic          hit;
    logic          match_q;
    logic [CW-1:0] count_q;
    state_t        state;
    state_t        state_next;

    seq_shift_reg #(.N(N)) u_hist (
        .ck        (ck),
        .reset     (reset),
        .en        (bus.en),
        .clr       (bus.clr),
        .d         (bus.d),
        .hist      (hist),
        .hist_next (hist_next)
    );

    always_comb begin
        fill_next  = (fill == FULL) ? FULL : fill + 1'b1;
        hit        = (fill_next == FULL) && (hist_next == PATTERN);
        fill_d     = fill;
        state_next = state;
        if (bus.clr) begin
            fill_d     = '0;
            state_next = FILL;
        end else if (bus.en) begin
            // Non-overlapping mode forgets the window so the next match needs N fresh bits
            if (hit && (OVERLAP == 0)) begin
                fill_d     = '0;
                state_next = FILL;
            end else begin
                fill_d = fill_next;
                if (fill_next == FULL) begin
                    state_next = ARMED;
                end
            end
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state   <= FILL;
            fill    <= '0;
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            state <= state_next;
            fill  <= fill_d;
            if (bus.clr) begin
                match_q <= 1'b0;
                count_q <= '0;
            end else begin
                match_q <= bus.en && hit;
                if (bus.en && hit && (count_q != {CW{1'b1}})) begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign bus.match = match_q;
    assign bus.armed = (state == ARMED);
    assign bus.count = count_q;

endmodule

// File: tb/tb_sequence_detector.sv
// tb/tb_sequence_detector.sv - self-checking bench: directed scenarios plus random stream vs queue model
module tb_sequence_detector;

    logic ck = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #10 ck = ~ck;

    sequence_detector_if #(.CW(8)) if0 ();
    sequence_detector_if #(.CW(8)) if1 ();
    sequence_detector_if #(.CW(2)) if2 ();

    sequence_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CW(8)) dut0 (.ck(ck), .reset(reset), .bus(if0.slave));
    sequence_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(0), .CW(8)) dut1 (.ck(ck), .reset(reset), .bus(if1.slave));
    sequence_detector #(.N(4), .PATTERN(4'b1011), .OVERLAP(1), .CW(2)) dut2 (.ck(ck), .reset(reset), .bus(if2.slave));

    logic       obs_match [3];
    logic       obs_armed [3];
    logic [7:0] obs_count [3];

    assign obs_match[0] = if0.match;
    assign obs_match[1] = if1.match;
    assign obs_match[2] = if2.match;
    assign obs_armed[0] = if0.armed;
    assign obs_armed[1] = if1.armed;
    assign obs_armed[2] = if2.armed;
    assign obs_count[0] = if0.count;
    assign obs_count[1] = if1.count;
    assign obs_count[2] = {6'b0, if2.count};

    // Reference model: last-N enabled bits kept in a queue, compared against the pattern directly
    localparam bit [3:0] PAT = 4'b1011;
    int  max_count [3] = '{255, 255, 3};
    bit  overlap   [3] = '{1'b1, 1'b0, 1'b1};
    bit  q0 [$];
    bit  q1 [$];
    bit  q2 [$];
    logic       exp_match [3];
    logic       exp_armed [3];
    logic [7:0] exp_count [3];

    task automatic model_reset();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int c = 0; c < 3; c++) begin
            exp_match[c] = 1'b0;
            exp_armed[c] = 1'b0;
            exp_count[c] = 8'd0;
        end
    endtask

    task automatic model_one(input int c, input bit e, input bit b, input bit cl);
        bit q [$];
        case (c)
            0:       q = q0;
            1:       q = q1;
            default: q = q2;
        endcase
        if (cl) begin
            q.delete();
            exp_match[c] = 1'b0;
            exp_count[c] = 8'd0;
        end else if (e) begin
            q.push_back(b);
            if (q.size() > 4) void'(q.pop_front());
            exp_match[c] = (q.size() == 4) && (q[0] == PAT[3]) && (q[1] == PAT[2])
                           && (q[2] == PAT[1]) && (q[3] == PAT[0]);
            if (exp_match[c]) begin
                if (int'(exp_count[c]) < max_count[c]) exp_count[c] = exp_count[c] + 8'd1;
                if (!overlap[c]) q.delete();
            end
        end else begin
            exp_match[c] = 1'b0;
        end
        exp_armed[c] = (q.size() == 4);
        case (c)
            0:       q0 = q;
            1:       q1 = q;
            default: q2 = q;
        endcase
    endtask

    task automatic set_inputs(input bit e, input bit b, input bit cl);
        if0.en = e; if0.d = b; if0.clr = cl;
        if1.en = e; if1.d = b; if1.clr = cl;
        if2.en = e; if2.d = b; if2.clr = cl;
    endtask

    task automatic step(input bit e, input bit b, input bit cl);
        @(negedge ck);
        set_inputs(e, b, cl);
        @(posedge ck);
        #1;
        for (int c = 0; c < 3; c++) model_one(c, e, b, cl);
    endtask

    task automatic test_reset();
        set_inputs(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge ck);
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (obs_match[c] !== 1'b0 || obs_armed[c] !== 1'b0 || obs_count[c] !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got match=%b armed=%b count=%0d want 0/0/0",
                         c, obs_match[c], obs_armed[c], obs_count[c]);
            end
        end
        @(negedge ck);
        reset = 1'b1;
    endtask

    task automatic test_async_reset();
        bit bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, bits[i], 1'b0);
        n_cmp++;
        if (if0.match !== 1'b1 || if0.count !== 8'd1) begin
            n_fail++;
            $display("FAIL async_pre: got match=%b count=%0d want 1/1", if0.match, if0.count);
        end
        @(negedge ck);
        set_inputs(1'b0, 1'b0, 1'b0);
        #4;
        reset = 1'b0;
        #2;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (obs_match[c] !== 1'b0 || obs_armed[c] !== 1'b0 || obs_count[c] !== 8'd0) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got match=%b armed=%b count=%0d want 0/0/0",
                         c, obs_match[c], obs_armed[c], obs_count[c]);
            end
        end
        model_reset();
        @(negedge ck);
        reset = 1'b1;
        // 0,1,1 would complete 1011 only if the pre-reset history survived
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (if0.match !== 1'b0 || if0.armed !== 1'b0) begin
            n_fail++;
            $display("FAIL async_history: got match=%b armed=%b want 0/0", if0.match, if0.armed);
        end
    endtask

    task automatic test_overlap();
        bit bits      [7] = '{1, 0, 1, 1, 0, 1, 1};
        bit want_m    [7] = '{0, 0, 0, 1, 0, 0, 1};
        bit want_a    [7] = '{0, 0, 0, 1, 1, 1, 1};
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[i], 1'b0);
            n_cmp++;
            if (if0.match !== want_m[i] || if0.armed !== want_a[i]) begin
                n_fail++;
                $display("FAIL overlap bit%0d: got match=%b armed=%b want %b/%b",
                         i + 1, if0.match, if0.armed, want_m[i], want_a[i]);
            end
        end
        n_cmp++;
        if (if0.count !== 8'd2) begin
            n_fail++;
            $display("FAIL overlap_count: got %0d want 2", if0.count);
        end
    endtask

    task automatic test_no_overlap();
        bit bits   [10] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        bit want_m [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, bits[i], 1'b0);
            n_cmp++;
            if (if1.match !== want_m[i] || if1.match !== exp_match[1]) begin
                n_fail++;
                $display("FAIL no_overlap bit%0d: got match=%b want %b", i + 1, if1.match, want_m[i]);
            end
        end
        n_cmp++;
        if (if1.count !== 8'd2) begin
            n_fail++;
            $display("FAIL no_overlap_count: got %0d want 2", if1.count);
        end
    endtask

    task automatic test_en_gating();
        bit bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int pulses = 0;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[i], 1'b0);
            if (if0.match === 1'b1) pulses++;
            n_cmp++;
            if (if0.match !== (i == 3)) begin
                n_fail++;
                $display("FAIL en_gating bit%0d: got match=%b want %b", i + 1, if0.match, (i == 3));
            end
            for (int g = 0; g < 3; g++) begin
                step(1'b0, ($urandom_range(0, 1) == 1), 1'b0);
                if (if0.match === 1'b1) pulses++;
            end
        end
        n_cmp++;
        if (pulses != 1 || if0.count !== 8'd1) begin
            n_fail++;
            $display("FAIL en_gating_total: got pulses=%0d count=%0d want 1/1", pulses, if0.count);
        end
    endtask

    task automatic test_saturation();
        bit bits [16] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        logic [7:0] want_c;
        step(1'b0, 1'b0, 1'b1);
        want_c = 8'd0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, bits[i], 1'b0);
            if (i % 3 == 0 && i > 0) begin
                if (want_c < 8'd3) want_c = want_c + 8'd1;
                n_cmp++;
                if (if2.match !== 1'b1 || obs_count[2] !== want_c) begin
                    n_fail++;
                    $display("FAIL saturation bit%0d: got match=%b count=%0d want 1/%0d",
                             i + 1, if2.match, obs_count[2], want_c);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs_count[2] !== 8'd3 || if2.match !== 1'b0) begin
            n_fail++;
            $display("FAIL saturation_hold: got count=%0d match=%b want 3/0", obs_count[2], if2.match);
        end
    endtask

    task automatic test_clr_last_bit();
        bit bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, bits[i], 1'b0);
        step(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (obs_match[c] !== 1'b0 || obs_armed[c] !== 1'b0 || obs_count[c] !== 8'd0) begin
                n_fail++;
                $display("FAIL clr_collide dut%0d: got match=%b armed=%b count=%0d want 0/0/0",
                         c, obs_match[c], obs_armed[c], obs_count[c]);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b1, bits[i], 1'b0);
        n_cmp++;
        if (if0.match !== 1'b1 || if0.count !== 8'd1 || if0.armed !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_after: got match=%b count=%0d armed=%b want 1/1/1",
                     if0.match, if0.count, if0.armed);
        end
    endtask

    task automatic test_random();
        bit e, b, cl;
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            b  = ($urandom_range(0, 1) == 1);
            cl = ($urandom_range(0, 47) == 0);
            step(e, b, cl);
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (obs_match[c] !== exp_match[c] || obs_armed[c] !== exp_armed[c]
                    || obs_count[c] !== exp_count[c]) begin
                    n_fail++;
                    $display("FAIL random step%0d dut%0d: got %b/%b/%0d want %b/%b/%0d", i, c,
                             obs_match[c], obs_armed[c], obs_count[c],
                             exp_match[c], exp_armed[c], exp_count[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_overlap();
        test_no_overlap();
        test_en_gating();
        test_saturation();
        test_clr_last_bit();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
